// File: rtl/fifo_packetizer.sv
// Drains a synchronous FIFO and frames its data as header + PKT_LEN payload + checksum on a valid/ready stream.
// Optional sequence byte after the header when FIFO_PKT_SEQ_EN is defined.
module fifo_packetizer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 4,
    parameter logic [DATA_WIDTH-1:0] HDR_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    // state   | meaning
    // IDLE    | waiting for FIFO data, output empty
    // HDR     | header byte presented
    // SEQ     | sequence byte presented (optional build only)
    // PAYLOAD | pulling PKT_LEN bytes, one read in flight at most
    // CSUM    | checksum byte presented with out_last
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
`ifdef FIFO_PKT_SEQ_EN
    localparam logic [2:0] S_SEQ     = 3'd2;
`endif
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;

    localparam int               CNT_W   = $clog2(PKT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_LEN);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  inflight_q, inflight_d;
`ifdef FIFO_PKT_SEQ_EN
    logic [7:0]            seq_q, seq_d;
`endif

    logic slot_free;
    logic accept;
    logic rd_en;

    assign slot_free = !valid_q || out_ready;
    assign accept    = valid_q && out_ready;

    // Gated by rst so nothing is popped during the reset cycle itself.
    assign rd_en = rst && (state_q == S_PAYLOAD) && !fifo_empty && !inflight_q
                   && (cnt_q < CNT_MAX) && slot_free;

    assign fifo_rd_en = rd_en;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        last_d     = last_q;
        inflight_d = rd_en;
`ifdef FIFO_PKT_SEQ_EN
        seq_d      = seq_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    data_d  = HDR_BYTE;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
`ifdef FIFO_PKT_SEQ_EN
                    data_d  = DATA_WIDTH'(seq_q);
                    valid_d = 1'b1;
                    state_d = S_SEQ;
`else
                    valid_d = 1'b0;
                    state_d = S_PAYLOAD;
`endif
                end
            end
`ifdef FIFO_PKT_SEQ_EN
            S_SEQ: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = S_PAYLOAD;
                end
            end
`endif
            S_PAYLOAD: begin
                if (accept) begin
                    valid_d = 1'b0;
                end
                // A read is only issued with the slot free, so the returning byte always fits.
                if (inflight_q) begin
                    data_d  = fifo_dout;
                    valid_d = 1'b1;
                    sum_d   = sum_q + fifo_dout;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (accept && (cnt_q == CNT_MAX)) begin
                    data_d  = '0 - sum_q;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef FIFO_PKT_SEQ_EN
                    seq_d   = seq_q + 8'd1;
`endif
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            inflight_q <= 1'b0;
`ifdef FIFO_PKT_SEQ_EN
            seq_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            inflight_q <= inflight_d;
`ifdef FIFO_PKT_SEQ_EN
            seq_q      <= seq_d;
`endif
        end
    end

endmodule
